// File: rtl/md5_pkg.sv
// Shared types for the MD5 front end: block geometry, word type, padder states
// and the byte-lane write helper.
package md5_pkg;

  localparam int MD5_BLK_WORDS = 16;
  localparam int MD5_WORD_W    = 32;

  typedef logic [MD5_WORD_W-1:0] md5_word_t;

  typedef enum logic [2:0] {FILL, PAD80, ZERO, LEN, EMIT} pad_state_t;

  // Replace one little-endian byte lane of a block word.
  function automatic md5_word_t md5_put_byte(md5_word_t w, logic [1:0] lane, logic [7:0] b);
    md5_word_t r;
    r = w;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/md5_pad_loader.sv
// MD5 byte-stream loader: packs bytes into 16x32-bit blocks and appends MD5 padding.
// Optional MD5_PAD_BLKCNT_EN adds blk_cnt_o, a free-running count of delivered blocks.
module md5_pad_loader
  import md5_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
  input  logic       byte_last_i,
  input  logic       byte_keep_i,
  output logic       byte_ready_o,
  output md5_word_t  M_o [0:MD5_BLK_WORDS-1],
  output logic       blk_valid_o,
  output logic       blk_last_o,
  input  logic       blk_ready_i
`ifdef MD5_PAD_BLKCNT_EN
  , output logic [31:0] blk_cnt_o
`endif
);

  pad_state_t  state, state_n;
  pad_state_t  ret, ret_n;
  logic [5:0]  idx, idx_n;
  logic [63:0] len, len_n;
  logic        fin, fin_n;
  logic        wrap, wrap_n;
  logic        wr_en;
  logic [7:0]  wr_byte;

  always_comb begin
    state_n      = state;
    ret_n        = ret;
    idx_n        = idx;
    len_n        = len;
    fin_n        = fin;
    wrap_n       = wrap;
    wr_en        = 1'b0;
    wr_byte      = 8'h00;
    byte_ready_o = 1'b0;
    blk_valid_o  = 1'b0;
    blk_last_o   = 1'b0;
    case (state)
      FILL: begin
        byte_ready_o = 1'b1;
        if (byte_valid_i) begin
          if (byte_keep_i) begin
            wr_en   = 1'b1;
            wr_byte = byte_i;
            idx_n   = idx + 6'd1;
            len_n   = len + 64'd8;
          end
          if (byte_keep_i && idx == 6'd63) begin
            state_n = EMIT;
            ret_n   = byte_last_i ? PAD80 : FILL;
          end else if (byte_last_i) begin
            state_n = PAD80;
          end
        end
      end
      PAD80: begin
        wr_en   = 1'b1;
        wr_byte = 8'h80;
        idx_n   = idx + 6'd1;
        // 0x80 at byte 55 leaves no zero fill; past 55 the length needs a fresh block.
        if (idx == 6'd63) begin
          state_n = EMIT;
          ret_n   = ZERO;
        end else if (idx == 6'd55) begin
          state_n = LEN;
        end else if (idx < 6'd55) begin
          state_n = ZERO;
        end else begin
          state_n = ZERO;
          wrap_n  = 1'b1;
        end
      end
      ZERO: begin
        wr_en = 1'b1;
        idx_n = idx + 6'd1;
        if (wrap && idx == 6'd63) begin
          state_n = EMIT;
          ret_n   = ZERO;
          wrap_n  = 1'b0;
        end else if (!wrap && idx == 6'd55) begin
          state_n = LEN;
        end
      end
      LEN: begin
        wr_en   = 1'b1;
        wr_byte = len[{idx[2:0], 3'b000} +: 8];
        idx_n   = idx + 6'd1;
        if (idx == 6'd63) begin
          state_n = EMIT;
          ret_n   = FILL;
          fin_n   = 1'b1;
        end
      end
      EMIT: begin
        blk_valid_o = 1'b1;
        blk_last_o  = fin;
        if (blk_ready_i) begin
          idx_n = 6'd0;
          if (fin) begin
            state_n = FILL;
            len_n   = 64'd0;
            fin_n   = 1'b0;
          end else begin
            state_n = ret;
          end
        end
      end
      default: state_n = FILL;
    endcase
    if (rst_i) begin
      byte_ready_o = 1'b0;
      blk_valid_o  = 1'b0;
      blk_last_o   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= FILL;
      ret   <= FILL;
      idx   <= 6'd0;
      len   <= 64'd0;
      fin   <= 1'b0;
      wrap  <= 1'b0;
      for (int i = 0; i < MD5_BLK_WORDS; i++) M_o[i] <= '0;
    end else begin
      state <= state_n;
      ret   <= ret_n;
      idx   <= idx_n;
      len   <= len_n;
      fin   <= fin_n;
      wrap  <= wrap_n;
      if (wr_en) M_o[idx[5:2]] <= md5_put_byte(M_o[idx[5:2]], idx[1:0], wr_byte);
    end
  end

`ifdef MD5_PAD_BLKCNT_EN
  logic blk_take;
  assign blk_take = blk_valid_o & blk_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) blk_cnt_o <= 32'd0;
    else if (blk_take) blk_cnt_o <= blk_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_md5_pad_loader.sv
// Bench for md5_pad_loader: directed vector table, stall/reset sequences and
// randomized messages checked against a padded-byte-array reference.
module tb_md5_pad_loader;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i, byte_last_i, byte_keep_i;
  logic        byte_ready_o;
  logic [31:0] m [0:15];
  logic        blk_valid_o, blk_last_o, blk_ready_i;
`ifdef MD5_PAD_BLKCNT_EN
  logic [31:0] blk_cnt;
`endif

  always #5 clk = ~clk;

  md5_pad_loader dut (
    .clk_i(clk), .rst_i(rst_i), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .byte_last_i(byte_last_i), .byte_keep_i(byte_keep_i), .byte_ready_o(byte_ready_o),
    .M_o(m), .blk_valid_o(blk_valid_o), .blk_last_o(blk_last_o), .blk_ready_i(blk_ready_i)
`ifdef MD5_PAD_BLKCNT_EN
    , .blk_cnt_o(blk_cnt)
`endif
  );

  int ncmp = 0;
  int nfail = 0;
  int edges = 0;

  logic [7:0]  msg [$];
  logic [31:0] cap_m [0:7][0:15];
  bit          cap_last [0:7];
  int          ncap;
  logic [31:0] exp_m [0:7][0:15];
  int          exp_nblk;

  // word 0..15 = block word, 16 = last flag, 17 = number of blocks
  typedef struct {
    int          mid;
    int          blk;
    int          word;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int mid, input int blk, input int word, input logic [31:0] exp);
    vec_t v;
    v.mid = mid; v.blk = blk; v.word = word; v.exp = exp;
    tbl.push_back(v);
  endtask

  // Reference: the standard MD5 padded byte stream, cut into 64-byte blocks.
  task automatic build_ref();
    logic [7:0]  p [$];
    logic [63:0] bits;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int k = 0; k < 8; k++) p.push_back(bits[8*k +: 8]);
    exp_nblk = p.size() / 64;
    for (int b = 0; b < exp_nblk; b++)
      for (int w = 0; w < 16; w++)
        exp_m[b][w] = {p[b*64+w*4+3], p[b*64+w*4+2], p[b*64+w*4+1], p[b*64+w*4]};
  endtask

  task automatic set_msg(input int n, input logic [7:0] val, input bit rnd);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(rnd ? 8'($urandom) : val);
  endtask

  task automatic set_abc();
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
  endtask

  task automatic run_msg(input int stall, input bit gaps, input bit chk_lat);
    int i = 0;
    bit sent = 0;
    bit done = 0;
    int cyc = 0;
    int stall_left = stall;
    bit snap_ok = 0;
    bit seen_valid = 0;
    int e0 = -1;
    logic [31:0] snap [0:15];
    logic snap_last;
    bit diff;
    ncap = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (!sent && (!gaps || $urandom_range(0, 3) != 0)) begin
        byte_valid_i = 1'b1;
        if (msg.size() == 0) begin
          byte_i = 8'($urandom); byte_keep_i = 1'b0; byte_last_i = 1'b1;
        end else begin
          byte_i = msg[i]; byte_keep_i = 1'b1; byte_last_i = (i == msg.size() - 1);
        end
      end else begin
        byte_valid_i = 1'b0; byte_keep_i = 1'b0; byte_last_i = 1'b0; byte_i = 8'($urandom);
      end
      blk_ready_i = 1'b0;
      if (blk_valid_o) begin
        if (!seen_valid) begin
          seen_valid = 1;
          if (chk_lat) chk("latency", 64'(edges - e0), 64'd63);
        end
        if (!snap_ok) begin
          snap = m; snap_last = blk_last_o; snap_ok = 1;
        end else begin
          diff = (snap_last !== blk_last_o);
          for (int w = 0; w < 16; w++) if (snap[w] !== m[w]) diff = 1;
          chk("stall_hold", 64'(diff), 64'd0);
        end
        if (stall_left > 0) stall_left--;
        else blk_ready_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      end else if (snap_ok) begin
        chk("valid_hold", 64'(blk_valid_o), 64'd1);
        snap_ok = 0;
      end
      if (byte_valid_i && byte_ready_o) begin
        if (e0 < 0) e0 = edges + 1;
        if (msg.size() == 0 || i == msg.size() - 1) sent = 1;
        else i++;
      end
      if (blk_valid_o && blk_ready_i) begin
        if (ncap < 8) begin
          for (int w = 0; w < 16; w++) cap_m[ncap][w] = m[w];
          cap_last[ncap] = blk_last_o;
        end
        ncap++;
        snap_ok = 0;
        if (blk_last_o) done = 1;
      end
      @(posedge clk);
      edges++;
    end
    @(negedge clk);
    byte_valid_i = 1'b0; byte_keep_i = 1'b0; byte_last_i = 1'b0; blk_ready_i = 1'b0;
    if (!done) chk("msg_timeout", 64'(cyc), 64'd0);
  endtask

  task automatic chk_table(input int mid);
    logic [63:0] act;
    foreach (tbl[k]) begin
      if (tbl[k].mid == mid) begin
        if (tbl[k].word == 17) act = 64'(ncap);
        else if (tbl[k].blk >= ncap) act = 'x;
        else if (tbl[k].word == 16) act = 64'(cap_last[tbl[k].blk]);
        else act = 64'(cap_m[tbl[k].blk][tbl[k].word]);
        chk($sformatf("vec m%0d b%0d w%0d", mid, tbl[k].blk, tbl[k].word), act, 64'(tbl[k].exp));
      end
    end
  endtask

  task automatic chk_ref(input string tag);
    chk({tag, "_nblk"}, 64'(ncap), 64'(exp_nblk));
    for (int b = 0; b < exp_nblk && b < ncap && b < 8; b++) begin
      chk($sformatf("%s_last b%0d", tag, b), 64'(cap_last[b]), 64'(b == exp_nblk - 1));
      for (int w = 0; w < 16; w++)
        chk($sformatf("%s b%0d w%0d", tag, b, w), 64'(cap_m[b][w]), 64'(exp_m[b][w]));
    end
  endtask

  initial begin
    bit all_zero;
    int lens [7] = '{55, 56, 57, 63, 64, 119, 120};
`ifdef MD5_PAD_BLKCNT_EN
    logic [31:0] cnt0;
`endif
    // "abc"
    add(0, 0, 0, 32'h80636261); add(0, 0, 1, 32'h0); add(0, 0, 13, 32'h0);
    add(0, 0, 14, 32'h18); add(0, 0, 15, 32'h0); add(0, 0, 16, 32'h1); add(0, 0, 17, 32'h1);
    // empty
    add(1, 0, 0, 32'h80); add(1, 0, 1, 32'h0); add(1, 0, 14, 32'h0); add(1, 0, 15, 32'h0);
    add(1, 0, 16, 32'h1); add(1, 0, 17, 32'h1);
    // 56 x 0x00
    add(2, 0, 13, 32'h0); add(2, 0, 14, 32'h80); add(2, 0, 15, 32'h0); add(2, 0, 16, 32'h0);
    add(2, 1, 0, 32'h0); add(2, 1, 13, 32'h0); add(2, 1, 14, 32'h1C0); add(2, 1, 15, 32'h0);
    add(2, 1, 16, 32'h1); add(2, 0, 17, 32'h2);
    // 64 x 0x01
    add(3, 0, 0, 32'h01010101); add(3, 0, 15, 32'h01010101); add(3, 0, 16, 32'h0);
    add(3, 1, 0, 32'h80); add(3, 1, 1, 32'h0); add(3, 1, 14, 32'h200); add(3, 1, 15, 32'h0);
    add(3, 1, 16, 32'h1); add(3, 0, 17, 32'h2);

    rst_i = 1'b1; byte_i = 8'h00; byte_valid_i = 1'b0; byte_last_i = 1'b0;
    byte_keep_i = 1'b0; blk_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(byte_ready_o), 64'd0);
    chk("rst_valid", 64'(blk_valid_o), 64'd0);
    rst_i = 1'b0;
    #1;
    chk("post_rst_ready", 64'(byte_ready_o), 64'd1);
    chk("post_rst_last", 64'(blk_last_o), 64'd0);
    all_zero = 1;
    for (int w = 0; w < 16; w++) if (m[w] !== 32'h0) all_zero = 0;
    chk("rst_m_zero", 64'(all_zero), 64'd1);
`ifdef MD5_PAD_BLKCNT_EN
    chk("rst_blkcnt", 64'(blk_cnt), 64'd0);
`endif

    for (int mid = 0; mid < 4; mid++) begin
      case (mid)
        0: set_abc();
        1: set_msg(0, 8'h00, 0);
        2: set_msg(56, 8'h00, 0);
        default: set_msg(64, 8'h01, 0);
      endcase
      run_msg(0, 0, mid == 0);
      chk_table(mid);
    end

    // Consumer holds off for 10 cycles; block must stay put.
    set_abc();
`ifdef MD5_PAD_BLKCNT_EN
    cnt0 = blk_cnt;
`endif
    run_msg(10, 0, 0);
    chk_table(0);
`ifdef MD5_PAD_BLKCNT_EN
    chk("blkcnt_step", 64'(blk_cnt - cnt0), 64'd1);
`endif

    // Reset while zero-filling, then a clean "abc".
    set_abc();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      byte_valid_i = 1'b1; byte_keep_i = 1'b1; byte_i = msg[i]; byte_last_i = (i == 2);
    end
    @(negedge clk);
    byte_valid_i = 1'b0; byte_keep_i = 1'b0; byte_last_i = 1'b0;
    repeat (6) @(negedge clk);
    chk("zero_stalls_input", 64'(byte_ready_o), 64'd0);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("abort_valid", 64'(blk_valid_o), 64'd0);
    chk("abort_ready", 64'(byte_ready_o), 64'd1);
`ifdef MD5_PAD_BLKCNT_EN
    chk("abort_blkcnt", 64'(blk_cnt), 64'd0);
`endif
    run_msg(0, 0, 0);
    chk_table(0);

    for (int k = 0; k < 7; k++) begin
      set_msg(lens[k], 8'h00, 1);
      build_ref();
      run_msg($urandom_range(0, 3), 1, 0);
      chk_ref($sformatf("len%0d", lens[k]));
    end
    for (int t = 0; t < 30; t++) begin
      set_msg($urandom_range(0, 150), 8'h00, 1);
      build_ref();
`ifdef MD5_PAD_BLKCNT_EN
      cnt0 = blk_cnt;
`endif
      run_msg($urandom_range(0, 3), t[0], 0);
      chk_ref($sformatf("rnd%0d_n%0d", t, msg.size()));
`ifdef MD5_PAD_BLKCNT_EN
      chk("blkcnt_rnd", 64'(blk_cnt - cnt0), 64'(exp_nblk));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
